// File: rtl/mux_pipe.sv
// Registered CHANNELS:1 selector with a one-deep valid/ready output stage.
// Define MUX_PIPE_ERR_CNT_EN to add a saturating 8-bit out-of-range select counter (err_count).
module mux_pipe #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_err,
    output logic                      out_valid,
`ifdef MUX_PIPE_ERR_CNT_EN
    output logic [7:0]                err_count,
`endif
    input  logic                      out_ready
);

    localparam int unsigned Nodes = 2 ** SEL_W;

    if (CHANNELS > Nodes) begin : g_sel_w_chk
        $error("mux_pipe: CHANNELS exceeds 2**SEL_W");
    end
    if (WIDTH < 1 || WIDTH > 64) begin : g_width_chk
        $error("mux_pipe: WIDTH out of range 1..64");
    end
    if (CHANNELS < 2 || CHANNELS > 16) begin : g_channels_chk
        $error("mux_pipe: CHANNELS out of range 2..16");
    end

    logic [Nodes*WIDTH-1:0] padded;
    logic [WIDTH-1:0]       lvl [SEL_W+1][Nodes];
    logic [WIDTH-1:0]       sel_data;
    logic                   sel_err;
    logic                   accept;

    logic [1:0]       rst_sync_q;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_err_q, out_err_d;
    logic             out_valid_q, out_valid_d;

    // Balanced 2:1 tree: level l resolves in_sel[l], unused leaves are tied to zero.
    always_comb begin
        padded = '0;
        padded[CHANNELS*WIDTH-1:0] = in_data;
        for (int l = 0; l <= SEL_W; l++) begin
            for (int i = 0; i < Nodes; i++) begin
                lvl[l][i] = '0;
            end
        end
        for (int i = 0; i < Nodes; i++) begin
            lvl[0][i] = padded[i*WIDTH +: WIDTH];
        end
        for (int l = 0; l < SEL_W; l++) begin
            for (int i = 0; i < (Nodes >> (l + 1)); i++) begin
                lvl[l+1][i] = in_sel[l] ? lvl[l][2*i+1] : lvl[l][2*i];
            end
        end
        sel_err  = 32'(in_sel) >= CHANNELS;
        sel_data = sel_err ? '0 : lvl[SEL_W][0];
    end

    // Reset release is resynchronised; in_ready stays low until it has crossed both flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign in_ready = rst_sync_q[1] & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_data_d  = sel_data;
            out_err_d   = sel_err;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign out_valid = out_valid_q;

`ifdef MUX_PIPE_ERR_CNT_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (accept && sel_err && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= 8'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_mux_pipe.sv
// Scoreboard bench for mux_pipe: directed scenarios on an 8x3 instance plus
// random traffic on 1-bit/2-channel and 32-bit/16-channel instances every cycle.
module tb_mux_pipe;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // Main instance: WIDTH=8, CHANNELS=3, SEL_W=2
    logic [23:0] m_in_data = '0;
    logic [1:0]  m_in_sel = '0;
    logic        m_in_valid = 1'b0, m_out_ready = 1'b0;
    logic        m_in_ready, m_out_err, m_out_valid;
    logic [7:0]  m_out_data;
    // Sweep A: WIDTH=1, CHANNELS=2, SEL_W=2 (selects 2,3 are out of range)
    logic [1:0]  a_in_data = '0;
    logic [1:0]  a_in_sel = '0;
    logic        a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic        a_in_ready, a_out_err, a_out_valid;
    logic [0:0]  a_out_data;
    // Sweep B: WIDTH=32, CHANNELS=16, SEL_W=4
    logic [511:0] b_in_data = '0;
    logic [3:0]   b_in_sel = '0;
    logic         b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic         b_in_ready, b_out_err, b_out_valid;
    logic [31:0]  b_out_data;
`ifdef MUX_PIPE_ERR_CNT_EN
    logic [7:0] m_err_count, a_err_count, b_err_count;
`endif

    mux_pipe #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(m_in_data), .in_sel(m_in_sel),
        .in_valid(m_in_valid), .in_ready(m_in_ready), .out_data(m_out_data),
        .out_err(m_out_err), .out_valid(m_out_valid),
`ifdef MUX_PIPE_ERR_CNT_EN
        .err_count(m_err_count),
`endif
        .out_ready(m_out_ready)
    );

    mux_pipe #(.WIDTH(1), .CHANNELS(2), .SEL_W(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_sel(a_in_sel),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_err(a_out_err), .out_valid(a_out_valid),
`ifdef MUX_PIPE_ERR_CNT_EN
        .err_count(a_err_count),
`endif
        .out_ready(a_out_ready)
    );

    mux_pipe #(.WIDTH(32), .CHANNELS(16), .SEL_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_sel(b_in_sel),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_err(b_out_err), .out_valid(b_out_valid),
`ifdef MUX_PIPE_ERR_CNT_EN
        .err_count(b_err_count),
`endif
        .out_ready(b_out_ready)
    );

    int   n_checks = 0;
    int   n_fail = 0;
    int   rel_edges = 0;
    int   exp_cnt = 0;
    bit   m_vld = 1'b0, a_vld = 1'b0, b_vld = 1'b0;
    res_t mq[$];
    res_t aq[$];
    res_t bq[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic void clear_models();
        mq.delete();
        aq.delete();
        bq.delete();
        m_vld = 1'b0;
        a_vld = 1'b0;
        b_vld = 1'b0;
        exp_cnt = 0;
    endfunction

    // One clock cycle: drive on negedge, check and update models, then take the rising edge.
    task automatic step(input bit v, input logic [1:0] sel, input logic [23:0] d, input bit rdy);
        res_t r;
        bit   en;
        bit   arv, brv;
        @(negedge clk);
        m_in_valid  = v;
        m_in_sel    = sel;
        m_in_data   = d;
        m_out_ready = rdy;
        a_in_valid  = 1'($urandom_range(0, 1));
        a_in_sel    = 2'($urandom);
        a_in_data   = 2'($urandom);
        a_out_ready = ($urandom_range(0, 3) != 0);
        b_in_valid  = 1'($urandom_range(0, 1));
        b_in_sel    = 4'($urandom);
        for (int i = 0; i < 16; i++) b_in_data[i*32 +: 32] = $urandom;
        b_out_ready = ($urandom_range(0, 3) != 0);
        arv = a_out_ready;
        brv = b_out_ready;
        #1;
        en = (rel_edges >= 2);

        check("in_ready", m_in_ready, en && (!m_vld || rdy));
        check("out_valid", m_out_valid, m_vld);
        if (m_vld && mq.size() != 0) begin
            r = mq[0];
            check("out_data", m_out_data, r.data);
            check("out_err", m_out_err, r.err);
            if (rdy) void'(mq.pop_front());
        end
`ifdef MUX_PIPE_ERR_CNT_EN
        check("err_count", m_err_count, exp_cnt);
`endif
        if (v && en && (!m_vld || rdy)) begin
            r.err  = (sel >= 2'd3);
            r.data = '0;
            if (!r.err) r.data[7:0] = d[sel*8 +: 8];
            mq.push_back(r);
            m_vld = 1'b1;
            if (r.err && exp_cnt < 255) exp_cnt++;
        end else if (rdy) begin
            m_vld = 1'b0;
        end

        check("a_in_ready", a_in_ready, en && (!a_vld || arv));
        check("a_out_valid", a_out_valid, a_vld);
        if (a_vld && aq.size() != 0) begin
            r = aq[0];
            check("a_out_data", a_out_data, r.data);
            check("a_out_err", a_out_err, r.err);
            if (arv) void'(aq.pop_front());
        end
        if (a_in_valid && en && (!a_vld || arv)) begin
            r.err  = (a_in_sel >= 2'd2);
            r.data = '0;
            if (!r.err) r.data[0] = a_in_data[a_in_sel[0]];
            aq.push_back(r);
            a_vld = 1'b1;
        end else if (arv) begin
            a_vld = 1'b0;
        end

        check("b_in_ready", b_in_ready, en && (!b_vld || brv));
        check("b_out_valid", b_out_valid, b_vld);
        if (b_vld && bq.size() != 0) begin
            r = bq[0];
            check("b_out_data", b_out_data, r.data);
            check("b_out_err", b_out_err, r.err);
            if (brv) void'(bq.pop_front());
        end
        if (b_in_valid && en && (!b_vld || brv)) begin
            r.err  = 1'b0;
            r.data = b_in_data[b_in_sel*32 +: 32];
            bq.push_back(r);
            b_vld = 1'b1;
        end else if (brv) begin
            b_vld = 1'b0;
        end

        @(posedge clk);
        rel_edges++;
    endtask

    task automatic check_in_reset();
        check("rst_out_valid", m_out_valid, 1'b0);
        check("rst_out_err", m_out_err, 1'b0);
        check("rst_out_data", m_out_data, 8'h00);
        check("rst_in_ready", m_in_ready, 1'b0);
        check("rst_b_out_valid", b_out_valid, 1'b0);
`ifdef MUX_PIPE_ERR_CNT_EN
        check("rst_err_count", m_err_count, 8'd0);
`endif
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        rel_edges = 0;
    endtask

    localparam logic [23:0] Chans = 24'h332211;

    initial begin
        #1 rst_n = 1'b0;
        #1 check_in_reset();
        clear_models();
        release_reset();
        // Offers during the synchroniser window must not be taken.
        step(1'b1, 2'd0, Chans, 1'b1);
        step(1'b1, 2'd1, Chans, 1'b1);

        // basic select
        step(1'b1, 2'd0, Chans, 1'b1);
        step(1'b1, 2'd1, Chans, 1'b1);
        step(1'b1, 2'd2, Chans, 1'b1);
        // out-of-range select
        step(1'b1, 2'd3, Chans, 1'b1);
        step(1'b0, 2'd0, Chans, 1'b1);

        // backpressure: hold 0x22 for four cycles, then consume and accept together
        step(1'b1, 2'd1, Chans, 1'b1);
        repeat (4) step(1'b1, 2'd2, Chans, 1'b0);
        step(1'b1, 2'd2, Chans, 1'b1);
        step(1'b0, 2'd0, Chans, 1'b1);

        // reset mid-operation with a stalled result pending
        step(1'b1, 2'd0, 24'h00A5_00, 1'b1);
        step(1'b1, 2'd3, Chans, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_in_reset();
        clear_models();
        repeat (2) @(posedge clk);
        release_reset();
        step(1'b1, 2'd2, Chans, 1'b0);
        step(1'b1, 2'd2, Chans, 1'b0);
        step(1'b1, 2'd2, Chans, 1'b1);
        step(1'b0, 2'd0, Chans, 1'b1);

        // random traffic on all instances
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom), 24'($urandom),
                 $urandom_range(0, 3) != 0);
        end

`ifdef MUX_PIPE_ERR_CNT_EN
        // counter saturation
        for (int i = 0; i < 300; i++) step(1'b1, 2'd3, Chans, 1'b1);
        repeat (3) step(1'b1, 2'd3, Chans, 1'b1);
        step(1'b0, 2'd0, Chans, 1'b1);
        check("err_count_sat", m_err_count, 8'd255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
